// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: word/counter widths,
// reset defaults and the per-edge update decision used by PC and IF/ID.
package fetch_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        UPD_LOAD  = 2'd0,
        UPD_HOLD  = 2'd1,
        UPD_FLUSH = 2'd2
    } upd_e;

    // A taken branch wins over a stall request on the same edge.
    function automatic upd_e resolve_update(input logic pc_src, input logic stall);
        if (pc_src) begin
            return UPD_FLUSH;
        end else if (stall) begin
            return UPD_HOLD;
        end
        return UPD_LOAD;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: captures instruction and its plus1, holds on
// stall and loads a NOP bubble on flush or reset.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  upd_e            upd_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] plus1_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] plus1_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] plus1_q, plus1_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        plus1_d = plus1_q;
        valid_d = valid_q;
        unique case (upd_i)
            UPD_LOAD: begin
                instr_d = instr_i;
                plus1_d = plus1_i;
                valid_d = 1'b1;
            end
            UPD_FLUSH: begin
                instr_d = NOP_INSTR;
                plus1_d = '0;
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            plus1_q <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            plus1_q <= plus1_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign plus1_o = plus1_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, incrementer, saturating stall counter
// and the IF/ID register. The PC select mux lives outside this block.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  nextPc,
    input  logic             pcSrc,
    input  logic             stall,
    input  logic [XLEN-1:0]  instrIn,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  plus1,
    output logic [XLEN-1:0]  ifidInstr,
    output logic [XLEN-1:0]  ifidPlus1,
    output logic             ifidValid,
    output logic [CNT_W-1:0] stallCycles
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    upd_e             upd;

    assign upd = resolve_update(pcSrc, stall);

    // nextPc is only consumed on edges where the PC actually moves.
    always_comb begin
        pc_d        = pc_q;
        stall_cnt_d = stall_cnt_q;
        unique case (upd)
            UPD_LOAD,
            UPD_FLUSH: pc_d = nextPc;
            UPD_HOLD:  stall_cnt_d = sat_inc(stall_cnt_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign plus1       = pc_q + 32'd1;
    assign stallCycles = stall_cnt_q;

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .upd_i   (upd),
        .instr_i (instrIn),
        .plus1_i (plus1),
        .instr_o (ifidInstr),
        .plus1_o (ifidPlus1),
        .valid_o (ifidValid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a counter
// saturation sequence and a randomized run against a behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] nextPc;
    logic        pcSrc;
    logic        stall;
    logic [31:0] instrIn;
    logic [31:0] pc;
    logic [31:0] plus1;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPlus1;
    logic        ifidValid;
    logic [15:0] stallCycles;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nextPc      (nextPc),
        .pcSrc       (pcSrc),
        .stall       (stall),
        .instrIn     (instrIn),
        .pc          (pc),
        .plus1       (plus1),
        .ifidInstr   (ifidInstr),
        .ifidPlus1   (ifidPlus1),
        .ifidValid   (ifidValid),
        .stallCycles (stallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at address a is a*16.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return a << 4;
    endfunction

    assign instrIn = imem(pc);

    typedef struct {
        bit          rst;
        bit          src;
        bit          stl;
        bit          use_p1;
        logic [31:0] nx;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_p1;
        bit          e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit s, input bit t, input bit p,
                                input logic [31:0] nx, input logic [31:0] epc,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input bit ev, input logic [15:0] ec);
        vec_t v;
        v.rst = r; v.src = s; v.stl = t; v.use_p1 = p; v.nx = nx;
        v.e_pc = epc; v.e_instr = ei; v.e_p1 = ep; v.e_valid = ev; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit s, input bit t, input logic [31:0] nx);
        reset  = r;
        pcSrc  = s;
        stall  = t;
        nextPc = nx;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] epc, input logic [31:0] ei,
                             input logic [31:0] ep, input bit ev, input logic [15:0] ec);
        logic [31:0] ep1;
        ep1 = epc + 32'd1;
        chk({tag, " pc"},          pc,                    epc);
        chk({tag, " plus1"},       plus1,                 ep1);
        chk({tag, " ifidInstr"},   ifidInstr,             ei);
        chk({tag, " ifidPlus1"},   ifidPlus1,             ep);
        chk({tag, " ifidValid"},   {31'd0, ifidValid},    {31'd0, ev});
        chk({tag, " stallCycles"}, {16'd0, stallCycles},  {16'd0, ec});
    endtask

    vec_t        tbl[$];
    logic [31:0] prev_pc;

    // Behavioural reference state
    logic [31:0] m_pc, m_instr, m_p1;
    bit          m_valid;
    logic [15:0] m_cnt;

    initial begin
        reset = 1'b1; pcSrc = 1'b0; stall = 1'b0; nextPc = '0;

        //        rst src stl p1  nx            pc            instr         ifidPlus1     v  cnt
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h1,        32'h00,       32'h1,        1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h2,        32'h10,       32'h2,        1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h3,        32'h20,       32'h3,        1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h20,       32'h20,       32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h4,        32'h4,        32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h5,        32'h40,       32'h5,        1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h99,       32'h5,        32'h40,       32'h5,        1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 32'h123,      32'h5,        32'h40,       32'h5,        1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h6,        32'h50,       32'h6,        1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h7,        32'h60,       32'h7,        1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h8,        32'h70,       32'h8,        1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 32'h40,       32'h40,       32'h0,        32'h0,        0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h41,       32'h400,      32'h41,       1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h0,        32'hFFFFFFF0, 32'h0,        1, 2));
        for (int k = 3; k <= 7; k++)
            tbl.push_back(mk(0, 0, 1, 0, 32'hABC,  32'h0,        32'hFFFFFFF0, 32'h0,        1, 16'(k)));
        tbl.push_back(mk(1, 0, 1, 0, 32'h77,       32'h0,        32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,        32'h1,        32'h00,       32'h1,        1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h55,       32'h0,        32'h0,        32'h0,        0, 0));

        prev_pc = '0;
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].src, tbl[i].stl,
                  tbl[i].use_p1 ? prev_pc + 32'd1 : tbl[i].nx);
            check_all($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_instr,
                      tbl[i].e_p1, tbl[i].e_valid, tbl[i].e_cnt);
            prev_pc = tbl[i].e_pc;
        end

        // Saturation of the stall counter, then a branch+stall edge that must not count.
        apply(1, 0, 0, 32'h0);
        for (int k = 0; k < 65535; k++) apply(0, 0, 1, 32'h1234);
        check_all("sat_reach", 32'h0, 32'h0, 32'h0, 0, 16'hFFFF);
        apply(0, 0, 1, 32'h1234);
        check_all("sat_hold", 32'h0, 32'h0, 32'h0, 0, 16'hFFFF);
        apply(1, 0, 0, 32'h0);
        apply(0, 0, 1, 32'h0);
        apply(0, 1, 1, 32'h200);
        check_all("src_stl_nocount", 32'h200, 32'h0, 32'h0, 0, 16'd1);

        // Randomized run against the reference model.
        m_pc = '0; m_instr = '0; m_p1 = '0; m_valid = 0; m_cnt = '0;
        for (int i = 0; i < 3000; i++) begin
            bit          r, s, t;
            logic [31:0] nx;
            r  = (i == 0) || ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 5) == 0);
            t  = ($urandom_range(0, 3) == 0);
            nx = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd1;
            if (r) begin
                m_pc = 32'h0; m_instr = 32'h0; m_p1 = 32'h0; m_valid = 0; m_cnt = 16'h0;
            end else if (s) begin
                m_pc = nx; m_instr = 32'h0; m_p1 = 32'h0; m_valid = 0;
            end else if (t) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m_instr = imem(m_pc); m_p1 = m_pc + 32'd1; m_valid = 1; m_pc = nx;
            end
            apply(r, s, t, nx);
            check_all($sformatf("rnd%0d", i), m_pc, m_instr, m_p1, m_valid, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0000, instruction word inserted on flush or reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 nextPc  input  32  next PC chosen by the PC select mux (plus1 or branch address).
REQ-007 pcSrc  input  1  branch taken this cycle; the mux output is the branch target; flushes IF/ID.
REQ-008 stall  input  1  hazard-unit hold request for PC and IF/ID.
REQ-009 instrIn  input  32  instruction memory read data for address pc, combinational.
REQ-010 pc  output  32  current PC, drives instruction memory address.
REQ-011 plus1  output  32  pc + 1, feeds the PC select mux.
REQ-012 ifidInstr  output  32  registered instruction to decode.
REQ-013 ifidPlus1  output  32  registered plus1 of the captured instruction.
REQ-014 ifidValid  output  1  IF/ID holds a real instruction.
REQ-015 stallCycles  output  16  count of stalled cycles since reset, saturating.

Function
REQ-016 plus1 SHALL be pc + 1, modulo 2^32, combinational; 32'hFFFF_FFFF yields 32'h0000_0000.
REQ-017 PC update priority per rising edge SHALL be:
- reset: pc <= RESET_PC.
- pcSrc=1: pc <= nextPc.
- stall=1: pc holds.
- otherwise: pc <= nextPc.
REQ-018 IF/ID update priority per rising edge SHALL be:
- reset: ifidInstr=NOP_INSTR, ifidPlus1=0, ifidValid=0.
- pcSrc=1: ifidInstr=NOP_INSTR, ifidPlus1=0, ifidValid=0 (flush).
- stall=1: all IF/ID fields hold.
- otherwise: ifidInstr<=instrIn, ifidPlus1<=plus1, ifidValid<=1.
REQ-019 pcSrc and stall asserted in the same cycle SHALL resolve to redirect plus flush; the stall is ignored for that edge.
REQ-020 Latency SHALL be one clock: the instruction at pc appears on ifidInstr after the next rising edge, absent stall or flush.
REQ-021 stallCycles SHALL increment by 1 on each edge with stall=1 and pcSrc=0, saturate at 16'hFFFF, and be cleared by reset.
REQ-022 All outputs except plus1 SHALL be registered; no combinational path SHALL exist from stall or pcSrc to any output.
REQ-023 nextPc SHALL be sampled only on edges where the PC updates; a stalled edge SHALL ignore its value.

Reset
REQ-024 Reset values SHALL be:
- pc = RESET_PC, plus1 = RESET_PC + 1.
- ifidInstr = NOP_INSTR, ifidPlus1 = 0, ifidValid = 0.
- stallCycles = 0.
REQ-025 Reset SHALL override pcSrc and stall on the same edge.
REQ-026 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state.
REQ-027 The first edge after reset deasserts SHALL capture the instruction at RESET_PC.

Structure
REQ-028 A shared package SHALL hold the 32-bit word width, RESET_PC default, NOP_INSTR encoding, and the 16-bit counter width.
REQ-029 The IF/ID register (instr, plus1, valid with hold/flush) SHALL be a sub-module named ifid_reg.
REQ-030 PC register, incrementer and stall counter SHALL live in fetch_stage; the PC select mux stays a separate existing block.

Verification
REQ-031 Reset then 3 free-running cycles with nextPc=plus1, instrIn=pc*16 -> pc 0,1,2,3; ifidInstr 0x00,0x10,0x20 with ifidValid=1 from cycle 1.
REQ-032 stall=1 for 2 cycles at pc=5 -> pc stays 5, IF/ID holds its value, stallCycles=2; pc becomes 6 on the edge after release.
REQ-033 pcSrc=1 with nextPc=0x40 at pc=8 -> next pc=0x40, ifidValid=0, ifidInstr=NOP_INSTR; the following edge captures the instruction at 0x40.
REQ-034 pcSrc=1 and stall=1 together at pc=3, nextPc=0x20 -> pc=0x20, flush occurs, stallCycles unchanged.
REQ-035 pc forced to 32'hFFFF_FFFF via branch -> plus1=0; next free-running edge gives pc=0.
REQ-036 Reset asserted during a stall with stallCycles=7 -> all Reset values restored on that edge.
